// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner: hex glyph table,
// decode helper and inactive output levels.
package seg_pkg;

  // Active-high g..a patterns; element 0 (rightmost) is the glyph for 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] ALL_OFF_ACTIVE_LOW  = 8'hFF;
  localparam logic [7:0] ALL_OFF_ACTIVE_HIGH = 8'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

  function automatic logic [7:0] inactive_level(input logic active_low);
    return active_low ? ALL_OFF_ACTIVE_LOW : ALL_OFF_ACTIVE_HIGH;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot/digit counters for the scanner: cnt counts clk cycles within a slot,
// idx selects the digit being scanned.
module scan_prescaler #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 100000,
  parameter int BLANK_CYCLES = 256,
  localparam int CNT_W = $clog2(DIV),
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx_o,
  output logic             slot_end_o,
  output logic             frame_end_o,
  output logic             in_blank_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_digit;

  assign slot_end_o  = (cnt_q == CNT_W'(DIV - 1));
  assign last_digit  = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign frame_end_o = slot_end_o && last_digit;
  assign in_blank_o  = (int'(cnt_q) < BLANK_CYCLES);
  assign idx_o       = idx_q;

  always_comb begin
    cnt_d = slot_end_o ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_end_o) idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment controller with tear-free frame commit,
// anti-ghosting dead time and optional leading-zero blanking.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV            = 100000,
  parameter int BLANK_CYCLES   = 256,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]            SEG_OFF = inactive_level(SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  =
    NUM_DIGITS'(inactive_level(AN_ACTIVE_LOW != 0));

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seven_seg_scanner: NUM_DIGITS must be in 1..8");
  end
  if (DIV < 2) begin : g_bad_div
    $error("seven_seg_scanner: DIV must be >= 2");
  end
  if (BLANK_CYCLES >= DIV) begin : g_bad_blank
    $error("seven_seg_scanner: BLANK_CYCLES must be < DIV");
  end

  logic [IDX_W-1:0] idx;
  logic             slot_end, frame_end, in_blank;

  scan_prescaler #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DIV         (DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .idx_o      (idx),
    .slot_end_o (slot_end),
    .frame_end_o(frame_end),
    .in_blank_o (in_blank)
  );

  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d, an_raw, lz_hide;
  logic [7:0]              seg_q, seg_d, seg_raw;
  logic                    frame_tick_q, all_zero, show;

  // A load on the boundary cycle bypasses pending so it is not lost a frame.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp;
    end
    if (frame_end) begin
      act_val_d = load ? value : pend_val_q;
      act_dp_d  = load ? dp    : pend_dp_q;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is
  // inferred on the paths where a digit is hidden.
  always_comb begin
    lz_hide  = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero && (act_val_q[4*i +: 4] == 4'h0);
      lz_hide[i] = lz_blank && all_zero;
    end
    show    = !in_blank && digit_en[idx] && !lz_hide[idx];
    an_raw  = '0;
    seg_raw = '0;
    if (show) begin
      an_raw[idx] = 1'b1;
      seg_raw     = {act_dp_q[idx], hex_to_seg(act_val_q[4*idx +: 4])};
    end
    an_d  = an_raw ^ AN_OFF;
    seg_d = seg_raw ^ SEG_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_end;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

  a_frame_on_slot_end: assert property (
    @(posedge clk) disable iff (rst) frame_end |-> slot_end);

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised and directed bench for seven_seg_scanner (4 digits, DIV=8,
// BLANK_CYCLES=2, active-low outputs) against a frame-position model.
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int DV = 8;
  localparam int BC = 2;
  localparam int FR = ND * DV;

  localparam logic [6:0] DEC [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS(ND), .DIV(DV), .BLANK_CYCLES(BC),
    .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .digit_en(digit_en),
    .lz_blank(lz_blank), .load(load), .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  // Reference model: position within the frame is (edges since reset) mod FR.
  int          e;
  logic [15:0] m_val_act, m_val_pend;
  logic [3:0]  m_dp_act, m_dp_pend;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic        exp_tick;

  function automatic logic [11:0] predict(input int p, input logic [15:0] v,
                                          input logic [3:0] dpv, input logic [3:0] en,
                                          input logic lz);
    int c = p % DV;
    int d = p / DV;
    logic [3:0] nib;
    logic lit;
    nib = v[4*d +: 4];
    lit = (c >= BC) && en[d] && !(lz && d > 0 && (v >> (4*d)) == 16'h0);
    if (lit) return {~(4'b0001 << d), ~{dpv[d], DEC[nib]}};
    return {4'hF, 8'hFF};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e <= 0;
      m_val_act <= '0; m_val_pend <= '0; m_dp_act <= '0; m_dp_pend <= '0;
      exp_an <= 4'hF; exp_seg <= 8'hFF; exp_tick <= 1'b0;
    end else begin
      {exp_an, exp_seg} <= predict(e % FR, m_val_act, m_dp_act, digit_en, lz_blank);
      exp_tick <= (e % FR == FR - 1);
      if (e % FR == FR - 1) begin
        m_val_act <= load ? value : m_val_pend;
        m_dp_act  <= load ? dp    : m_dp_pend;
      end
      if (load) begin
        m_val_pend <= value;
        m_dp_pend  <= dp;
      end
      e <= e + 1;
    end
  end

  task automatic load_word(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    value = v; dp = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Returns at the negedge just before the first edge of a new frame.
  task automatic sync_frame();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (e % FR != 0 && guard < 3 * FR);
    if (e % FR != 0) begin
      n_bad++;
      $display("FAIL sync_frame: frame start not reached within %0d cycles", guard);
    end
  endtask

  task automatic test_reset();
    int first = 0, second = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (an !== 4'hF)       begin n_bad++; $display("FAIL reset_an: got %h want f", an); end
    n_cmp++; if (seg !== 8'hFF)     begin n_bad++; $display("FAIL reset_seg: got %h want ff", seg); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    rst = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
    end
    n_cmp++; if (first != FR)      begin n_bad++; $display("FAIL first_tick: got cycle %0d want %0d", first, FR); end
    n_cmp++; if (second != 2 * FR) begin n_bad++; $display("FAIL second_tick: got cycle %0d want %0d", second, 2 * FR); end
  endtask

  // Runs one frame comparing against the model and a fixed glyph/anode table.
  task automatic check_frame_const(input string name, input logic [7:0] segs [4],
                                   input logic [3:0] ans [4]);
    for (int k = 0; k < FR; k++) begin
      logic [3:0] want_an;
      logic [7:0] want_seg;
      @(negedge clk);
      want_an  = ((k % DV) >= BC) ? ans[k / DV]  : 4'hF;
      want_seg = ((k % DV) >= BC) ? segs[k / DV] : 8'hFF;
      n_cmp++;
      if (an !== want_an || seg !== want_seg) begin
        n_bad++;
        $display("FAIL %s k=%0d: an=%h seg=%h want an=%h seg=%h", name, k, an, seg, want_an, want_seg);
      end
      n_cmp++;
      if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
        n_bad++;
        $display("FAIL %s_model k=%0d: an=%h seg=%h tick=%b want an=%h seg=%h tick=%b",
                 name, k, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
      end
    end
  endtask

  task automatic test_hex_pattern();
    digit_en = 4'hF; lz_blank = 1'b0;
    load_word(16'h12AF, 4'h0);
    sync_frame();
    check_frame_const("hex12AF", '{8'h8E, 8'h88, 8'hA4, 8'hF9}, '{4'hE, 4'hD, 4'hB, 4'h7});
  endtask

  task automatic test_lz_blank();
    digit_en = 4'hF; lz_blank = 1'b1;
    load_word(16'h0050, 4'h0);
    sync_frame();
    check_frame_const("lz0050", '{8'hC0, 8'h92, 8'hFF, 8'hFF}, '{4'hE, 4'hD, 4'hF, 4'hF});
    lz_blank = 1'b0;
  endtask

  task automatic test_tear_free();
    logic [7:0] want_seg;
    digit_en = 4'hF; lz_blank = 1'b0;
    load_word(16'h12AF, 4'h0);
    sync_frame();
    for (int k = 0; k < 2 * FR; k++) begin
      @(negedge clk);
      if ((k % DV) < BC)  want_seg = 8'hFF;
      else if (k >= FR)   want_seg = 8'hF9;
      else                want_seg = (k / DV == 0) ? 8'h8E : (k / DV == 1) ? 8'h88 :
                                     (k / DV == 2) ? 8'hA4 : 8'hF9;
      n_cmp++;
      if (seg !== want_seg) begin
        n_bad++;
        $display("FAIL tear_free k=%0d: seg=%h want %h", k, seg, want_seg);
      end
      n_cmp++;
      if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
        n_bad++;
        $display("FAIL tear_model k=%0d: an=%h seg=%h want an=%h seg=%h", k, an, seg, exp_an, exp_seg);
      end
      if (k == 9)  begin value = 16'h1111; load = 1'b1; end
      if (k == 10) load = 1'b0;
    end
  endtask

  task automatic test_digit_en();
    lz_blank = 1'b0; digit_en = 4'b0101;
    load_word(16'h12AF, 4'b0001);
    sync_frame();
    check_frame_const("digit_en", '{8'h0E, 8'hFF, 8'hA4, 8'hFF}, '{4'hE, 4'hF, 4'hB, 4'hF});
    digit_en = 4'hF;
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
        n_bad++;
        $display("FAIL random k=%0d: an=%h seg=%h tick=%b want an=%h seg=%h tick=%b",
                 k, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
      end
      load = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        value = 16'($urandom_range(0, 16'hFFFF) >> (4 * $urandom_range(0, 4)));
        dp    = 4'($urandom);
        load  = 1'b1;
      end
      if ($urandom_range(0, 40) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 40) == 0) lz_blank = 1'($urandom);
    end
    load = 1'b0;
  endtask

  task automatic test_mid_reset();
    digit_en = 4'hF; lz_blank = 1'b0;
    load_word(16'h12AF, 4'h0);
    sync_frame();
    repeat (2 * DV + 5) @(negedge clk);
    n_cmp++;
    if (an !== 4'hB) begin n_bad++; $display("FAIL pre_reset_an: got %h want b", an); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (an !== 4'hF)   begin n_bad++; $display("FAIL async_reset_an: got %h want f", an); end
    n_cmp++; if (seg !== 8'hFF) begin n_bad++; $display("FAIL async_reset_seg: got %h want ff", seg); end
    @(negedge clk);
    rst = 1'b0;
    check_frame_const("after_reset", '{8'hC0, 8'hC0, 8'hC0, 8'hC0}, '{4'hE, 4'hD, 4'hB, 4'h7});
  endtask

  initial begin
    test_reset();
    test_hex_pattern();
    test_lz_blank();
    test_tear_free();
    test_digit_en();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
